// File: rtl/phase_pkg.sv
// phase_pkg
// Constants and types shared by phase1, phase1_loader and their benches.
//   DATA_WIDTH : element width in bits
//   NUM_ELEMS  : elements per vector (x and teta each)
//   N_BIT      : element index width
//   VEC_W      : width of one packed vector
//   LAST_IDX   : index of the final element of a vector
//   state_e    : loader frame state

package phase_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned NUM_ELEMS  = 8;
    localparam int unsigned N_BIT      = $clog2(NUM_ELEMS);
    localparam int unsigned VEC_W      = NUM_ELEMS * DATA_WIDTH;

    localparam logic [N_BIT-1:0] LAST_IDX = N_BIT'(NUM_ELEMS - 1);

    typedef enum logic [1:0] {
        LOAD_X = 2'd0,
        LOAD_T = 2'd1,
        HOLD   = 2'd2
    } state_e;

    // Lowest-numbered (most significant, since vectors are declared [0:VEC_W-1])
    // bit of element k within a packed vector.
    function automatic int unsigned elem_base(input int unsigned k);
        return k * DATA_WIDTH;
    endfunction

endpackage

// File: rtl/phase1_loader.sv
// phase1_loader
// Serial-to-parallel front end for phase1. Accepts one element per cycle over a
// valid/ready stream: NUM_ELEMS elements of x, then NUM_ELEMS elements of teta,
// with in_last on the final element. A complete frame is presented on x_out /
// teta_out with out_valid until the consumer asserts out_ready.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   in_valid  in   in_data / in_last valid
//   in_ready  out  element accepted this cycle if in_valid is also high
//   in_data   in   element, unsigned
//   in_last   in   final element of the frame
//   x_out     out  packed x, element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   teta_out  out  packed teta, same packing
//   out_valid out  x_out / teta_out hold a complete frame
//   out_ready in   consumer has taken the frame
//   frame_err out  one-cycle pulse on a framing violation

module phase1_loader
    import phase_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic [0:VEC_W-1]      x_out,
    output logic [0:VEC_W-1]      teta_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_err
);

    state_e             state_q, state_d;
    logic [N_BIT-1:0]   idx_q, idx_d;
    logic [0:VEC_W-1]   x_q, x_d;
    logic [0:VEC_W-1]   t_q, t_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_err_q, frame_err_d;

    logic                 accept;
    logic                 idx_last;
    logic                 x_wr;
    logic                 t_wr;
    logic [NUM_ELEMS-1:0] elem_sel;

    // in_ready is deliberately combinational on rst so that nothing is
    // accepted in a cycle whose edge is going to reset the block anyway.
    assign in_ready = (state_q != HOLD) && !rst;
    assign accept   = in_valid && in_ready;
    assign idx_last = (idx_q == LAST_IDX);

    // A byte is only stored when it is framed correctly: in_last must be high
    // exactly on the final teta element and low everywhere else. Badly framed
    // bytes are dropped.
    assign x_wr = accept && (state_q == LOAD_X) && !in_last;
    assign t_wr = accept && (state_q == LOAD_T) && (in_last == idx_last);

    // One-hot element decode of the write index.
    always_comb begin
        elem_sel = '0;
        for (int k = 0; k < int'(NUM_ELEMS); k++) begin
            elem_sel[k] = (idx_q == N_BIT'(k));
        end
    end

    // Vector write datapath.
    always_comb begin
        x_d = x_q;
        t_d = t_q;
        for (int unsigned k = 0; k < NUM_ELEMS; k++) begin
            if (x_wr && elem_sel[k]) begin
                x_d[elem_base(k) +: DATA_WIDTH] = in_data;
            end
            if (t_wr && elem_sel[k]) begin
                t_d[elem_base(k) +: DATA_WIDTH] = in_data;
            end
        end
    end

    // Frame control: state, index, presentation and error pulse.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;

        case (state_q)
            LOAD_X: begin
                if (accept) begin
                    if (in_last) begin
                        // Frame ended inside x: drop the byte and resync.
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                        state_d     = LOAD_X;
                    end else if (idx_last) begin
                        idx_d   = '0;
                        state_d = LOAD_T;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            LOAD_T: begin
                if (accept) begin
                    if (idx_last && in_last) begin
                        idx_d       = '0;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else if (idx_last || in_last) begin
                        // Either in_last came early or it is missing on the
                        // final element; in both cases the frame is dropped.
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                        state_d     = LOAD_X;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            HOLD: begin
                // in_ready is low here, so a simultaneous in_valid waits for
                // the next cycle.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    idx_d       = '0;
                    state_d     = LOAD_X;
                end
            end

            default: begin
                state_d     = LOAD_X;
                idx_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_X;
            idx_q       <= '0;
            x_q         <= '0;
            t_q         <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            t_q         <= t_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign x_out     = x_q;
    assign teta_out  = t_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/phase1_loader.md
# phase1_loader

Serial-to-parallel front end for `phase1`, the combinational hypothesis stage that computes `h` from `x` and `teta`. The block accepts one element per cycle over a valid/ready byte stream: first the NUM_ELEMS elements of `x`, then the NUM_ELEMS elements of `teta`. It checks frame framing and presents both packed vectors as stable registers with an output valid/ready handshake. `phase1` connects directly to `x_out`/`teta_out`; its `h` is meaningful whenever `out_valid` is high.

## Interface
- DATA_WIDTH, 8, element width in bits
- NUM_ELEMS, 8, elements per vector
- N_BIT, 3, index width, clog2(NUM_ELEMS)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data/in_last valid
- in_ready  out  1  block can accept an element this cycle
- in_data  in  DATA_WIDTH  element, unsigned
- in_last  in  1  marks final element of the frame (element 2*NUM_ELEMS-1)
- x_out  out  [0:NUM_ELEMS*DATA_WIDTH-1]  packed x, element k at bits [k*DATA_WIDTH : k*DATA_WIDTH+DATA_WIDTH-1]
- teta_out  out  same as x_out  packed teta, same packing
- out_valid  out  1  x_out/teta_out hold a complete frame
- out_ready  in  1  consumer has taken the frame
- frame_err  out  1  one-cycle pulse on a framing violation

## Operation
- Accept = in_valid && in_ready.
- State machine states:
  - LOAD_X: each accept writes in_data to x element idx, then idx++. On idx == NUM_ELEMS-1, go to LOAD_T and set idx to 0.
  - LOAD_T: each accept writes teta element idx, then idx++. On idx == NUM_ELEMS-1 with in_last=1, go to HOLD and set out_valid=1.
  - HOLD: in_ready=0; x_out/teta_out are frozen. When out_valid && out_ready, clear out_valid, set idx to 0 and go to LOAD_X.
- in_ready = (state != HOLD) && !rst.
- Framing errors:
  - An accept with in_last=1 on any element other than LOAD_T idx NUM_ELEMS-1 pulses frame_err for 1 cycle. That byte is discarded, idx is set to 0, and the state goes to LOAD_X.
  - An accept in LOAD_T at idx NUM_ELEMS-1 with in_last=0 pulses frame_err and goes to LOAD_X with idx 0. out_valid stays 0.
- Partially written vector registers on error are not cleared. They are overwritten by the next frame and are never presented, because out_valid stays 0.
- No arithmetic beyond the index counter. idx is N_BIT wide and never wraps past NUM_ELEMS-1 because the state transition resets it.

## Timing
- Reset values: state LOAD_X, idx 0, x_out 0, teta_out 0, out_valid 0, frame_err 0. in_ready is 0 during rst and 1 on the first cycle after.
- All outputs except in_ready are registered.
- Latency: out_valid rises on the cycle after the 2*NUM_ELEMS-th accept.
- Minimum frame period is 2*NUM_ELEMS+1 cycles: 2*NUM_ELEMS accepts plus one HOLD cycle when out_ready is held high. No overlap between presenting and loading.
- out_valid stays high and vectors stay stable until out_ready is sampled high. The consumer may hold out_ready high permanently.
- in_valid with in_ready=0 is ignored; upstream must hold in_data until accepted.
- rst mid-frame or in HOLD discards everything and restores reset values on the next edge. rst has priority over all other inputs.
- Simultaneous in_valid and out_ready in HOLD: only the handshake completes; the element is accepted no earlier than the next cycle.

## Structure
- Shared package `phase_pkg` holds:
  - DATA_WIDTH, NUM_ELEMS, N_BIT constants, also used by `phase1` and its bench.
  - State enum {LOAD_X, LOAD_T, HOLD}.
- Single module, no sub-module. The counter and element write decode are inline.

## Test plan
- Frame x = {0,0,0,0,0,0,2,4} and teta = {0,0,0,0,0,0,2,4}, in_last on element 15, out_ready=1:
  - x_out = teta_out = 64'h0000_0000_0000_0204.
  - out_valid high for exactly 1 cycle, 1 cycle after the last accept.
  - phase1 h = 20.
- Same frame with out_ready=0 for 5 cycles:
  - out_valid held, in_ready=0 for those 5 cycles, vectors unchanged.
  - Clears on the cycle after out_ready=1.
- in_last asserted on element 5 → frame_err 1 cycle, out_valid never rises. A following clean frame of x = teta = all 1s gives 64'h0101_0101_0101_0101 in both outputs.
- Element 15 accepted without in_last → frame_err pulse, out_valid stays 0, state returns to LOAD_X (in_ready=1).
- rst asserted after element 10 → all outputs return to reset values. A subsequent full frame loads correctly from element 0.
- Random in_valid gaps (about 50% duty), back-to-back frames: each presented frame matches the bytes sent in order, with no dropped or duplicated elements.
